// File: rtl/rf_sb.sv
// rtl/rf_sb.sv - parametrised register file with write bypass and per-register pending scoreboard
// Decode-stage storage: two combinational reads, one synchronous write, RAW-hazard pending bits.
module rf_sb #(
    parameter int WIDTH    = 32,
    parameter int NUM      = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] busW,
    input  logic [AW-1:0]    rW,
    input  logic             wE,
    input  logic [AW-1:0]    rA,
    input  logic [AW-1:0]    rB,
    output logic [WIDTH-1:0] busA,
    output logic [WIDTH-1:0] busB,
    input  logic             iE,
    input  logic [AW-1:0]    rI,
    output logic             pendA,
    output logic             pendB,
    output logic [AW:0]      pendCnt
);

    logic [WIDTH-1:0] r_regs [NUM];
    logic [NUM-1:0]   r_pend;
    logic [AW:0]      r_pend_cnt;

    logic [NUM-1:0]   w_pend_next;
    logic [AW:0]      w_pend_cnt_next;
    logic             w_wr_ok;
    logic             w_iss_ok;
    logic             w_hit_a;
    logic             w_hit_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Register 0 swallows writes and issues when it is the hardwired zero.
    assign w_wr_ok  = wE & ~((ZERO_REG != 0) & (rW == '0));
    assign w_iss_ok = iE & ~((ZERO_REG != 0) & (rI == '0));

    assign w_hit_a = (BYPASS != 0) & w_wr_ok & (rW == rA);
    assign w_hit_b = (BYPASS != 0) & w_wr_ok & (rW == rB);

    assign w_rd_a = ((ZERO_REG != 0) && (rA == '0)) ? '0 : r_regs[rA];
    assign w_rd_b = ((ZERO_REG != 0) && (rB == '0)) ? '0 : r_regs[rB];

    // Outputs are forced quiet during reset so a bypassed busW cannot leak out.
    assign busA    = rst ? '0 : (w_hit_a ? busW : w_rd_a);
    assign busB    = rst ? '0 : (w_hit_b ? busW : w_rd_b);
    assign pendA   = ~rst & r_pend[rA] & ~w_hit_a;
    assign pendB   = ~rst & r_pend[rB] & ~w_hit_b;
    assign pendCnt = r_pend_cnt;

    // Clear first, then set, so a same-cycle issue to the written register stays pending.
    always_comb begin
        w_pend_next     = r_pend;
        w_pend_cnt_next = '0;
        if (w_wr_ok) begin
            w_pend_next[rW] = 1'b0;
        end
        if (w_iss_ok) begin
            w_pend_next[rI] = 1'b1;
        end
        for (int i = 0; i < NUM; i++) begin
            w_pend_cnt_next = w_pend_cnt_next + {{AW{1'b0}}, w_pend_next[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[rW] <= busW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_next;
            r_pend_cnt <= w_pend_cnt_next;
        end
    end

endmodule

// File: tb/tb_rf_sb.sv
// tb/tb_rf_sb.sv - directed self-checking bench for rf_sb
// Runs a bypassing instance and a non-bypassing instance side by side on the same stimulus.
module tb_rf_sb;

    logic        clk;
    logic        rst;
    logic [31:0] busW;
    logic [4:0]  rW;
    logic        wE;
    logic [4:0]  rA;
    logic [4:0]  rB;
    logic        iE;
    logic [4:0]  rI;
    logic [31:0] busA, busB, nb_busA, nb_busB;
    logic        pendA, pendB, nb_pendA, nb_pendB;
    logic [5:0]  pendCnt, nb_pendCnt;

    int vectors;
    int miscompares;

    rf_sb #(.WIDTH(32), .NUM(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .busW(busW), .rW(rW), .wE(wE), .rA(rA), .rB(rB),
        .busA(busA), .busB(busB), .iE(iE), .rI(rI),
        .pendA(pendA), .pendB(pendB), .pendCnt(pendCnt)
    );

    rf_sb #(.WIDTH(32), .NUM(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .busW(busW), .rW(rW), .wE(wE), .rA(rA), .rB(rB),
        .busA(nb_busA), .busB(nb_busB), .iE(iE), .rI(rI),
        .pendA(nb_pendA), .pendB(nb_pendB), .pendCnt(nb_pendCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        wE = 1'b0; iE = 1'b0; busW = '0; rW = '0; rI = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); rA = 5'd3; rB = 5'd0;
        @(negedge clk);
        busW = 32'hDEADBEEF; rW = 5'd3; wE = 1'b1;
        #1;
        vectors++;
        if (busA !== 32'h0) begin miscompares++; $display("FAIL reset_bypass_gated busA=%h exp=%h", busA, 32'h0); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; idle_inputs();
        @(posedge clk); #1;
        vectors++;
        if (busA !== 32'h0) begin miscompares++; $display("FAIL reset_write_ignored busA=%h exp=%h", busA, 32'h0); end
        vectors++;
        if (pendCnt !== 6'd0) begin miscompares++; $display("FAIL reset_pendcnt pendCnt=%0d exp=0", pendCnt); end
        vectors++;
        if (pendA !== 1'b0) begin miscompares++; $display("FAIL reset_penda pendA=%b exp=0", pendA); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wE = 1'b1; rW = 5'd5; busW = 32'h1234;
        @(negedge clk);
        rW = 5'd0; busW = 32'hFFFF;
        @(negedge clk);
        idle_inputs(); rA = 5'd5; rB = 5'd0;
        #1;
        vectors++;
        if (busA !== 32'h1234) begin miscompares++; $display("FAIL write_read_r5 busA=%h exp=%h", busA, 32'h1234); end
        vectors++;
        if (busB !== 32'h0) begin miscompares++; $display("FAIL zero_reg_read busB=%h exp=%h", busB, 32'h0); end
        vectors++;
        if (nb_busA !== 32'h1234) begin miscompares++; $display("FAIL nb_write_read_r5 busA=%h exp=%h", nb_busA, 32'h1234); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wE = 1'b1; rW = 5'd7; busW = 32'hA5A5; rA = 5'd7; rB = 5'd7;
        #1;
        vectors++;
        if (busA !== 32'hA5A5) begin miscompares++; $display("FAIL bypass_a busA=%h exp=%h", busA, 32'hA5A5); end
        vectors++;
        if (busB !== 32'hA5A5) begin miscompares++; $display("FAIL bypass_b busB=%h exp=%h", busB, 32'hA5A5); end
        vectors++;
        if (nb_busA !== 32'h0) begin miscompares++; $display("FAIL nobypass_old busA=%h exp=%h", nb_busA, 32'h0); end
        @(posedge clk); #1;
        vectors++;
        if (nb_busA !== 32'hA5A5) begin miscompares++; $display("FAIL nobypass_after_edge busA=%h exp=%h", nb_busA, 32'hA5A5); end
        @(negedge clk);
        wE = 1'b1; rW = 5'd0; busW = 32'h5555; rA = 5'd0;
        #1;
        vectors++;
        if (busA !== 32'h0) begin miscompares++; $display("FAIL bypass_dropped_r0 busA=%h exp=%h", busA, 32'h0); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        iE = 1'b1; rI = 5'd9; rA = 5'd9; rB = 5'd9;
        #1;
        vectors++;
        if (pendA !== 1'b0) begin miscompares++; $display("FAIL sb_not_yet_pending pendA=%b exp=0", pendA); end
        @(negedge clk);
        iE = 1'b0;
        #1;
        vectors++;
        if (pendA !== 1'b1) begin miscompares++; $display("FAIL sb_pending_a pendA=%b exp=1", pendA); end
        vectors++;
        if (pendB !== 1'b1) begin miscompares++; $display("FAIL sb_pending_b pendB=%b exp=1", pendB); end
        vectors++;
        if (pendCnt !== 6'd1) begin miscompares++; $display("FAIL sb_pendcnt_one pendCnt=%0d exp=1", pendCnt); end
        @(negedge clk);
        wE = 1'b1; rW = 5'd9; busW = 32'h77;
        #1;
        vectors++;
        if (pendA !== 1'b0) begin miscompares++; $display("FAIL sb_bypass_clears pendA=%b exp=0", pendA); end
        vectors++;
        if (nb_pendA !== 1'b1) begin miscompares++; $display("FAIL sb_nobypass_still pendA=%b exp=1", nb_pendA); end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (pendCnt !== 6'd0) begin miscompares++; $display("FAIL sb_pendcnt_zero pendCnt=%0d exp=0", pendCnt); end
        vectors++;
        if (nb_pendA !== 1'b0) begin miscompares++; $display("FAIL sb_nobypass_cleared pendA=%b exp=0", nb_pendA); end
        @(negedge clk);
        iE = 1'b1; rI = 5'd0; rA = 5'd0;
        @(negedge clk);
        iE = 1'b0;
        #1;
        vectors++;
        if (pendCnt !== 6'd0) begin miscompares++; $display("FAIL sb_r0_never_pending pendCnt=%0d exp=0", pendCnt); end
        @(negedge clk);
        wE = 1'b1; rW = 5'd12; busW = 32'h1;
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (pendCnt !== 6'd0) begin miscompares++; $display("FAIL sb_write_nonpending pendCnt=%0d exp=0", pendCnt); end
    endtask

    task automatic test_issue_write();
        @(negedge clk);
        iE = 1'b1; rI = 5'd4;
        @(negedge clk);
        iE = 1'b1; rI = 5'd4;
        #1;
        vectors++;
        if (pendCnt !== 6'd1) begin miscompares++; $display("FAIL iw_pendcnt_before pendCnt=%0d exp=1", pendCnt); end
        @(negedge clk);
        iE = 1'b1; rI = 5'd4; wE = 1'b1; rW = 5'd4; busW = 32'hBEEF; rA = 5'd4;
        #1;
        vectors++;
        if (busA !== 32'hBEEF) begin miscompares++; $display("FAIL iw_bypass_data busA=%h exp=%h", busA, 32'hBEEF); end
        vectors++;
        if (pendCnt !== 6'd1) begin miscompares++; $display("FAIL iw_reissue_count pendCnt=%0d exp=1", pendCnt); end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (pendA !== 1'b1) begin miscompares++; $display("FAIL iw_set_wins pendA=%b exp=1", pendA); end
        vectors++;
        if (pendCnt !== 6'd1) begin miscompares++; $display("FAIL iw_pendcnt_after pendCnt=%0d exp=1", pendCnt); end
        vectors++;
        if (busA !== 32'hBEEF) begin miscompares++; $display("FAIL iw_data_updated busA=%h exp=%h", busA, 32'hBEEF); end
        @(negedge clk);
        wE = 1'b1; rW = 5'd4; busW = 32'hBEEF;
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (pendCnt !== 6'd0) begin miscompares++; $display("FAIL iw_cleared pendCnt=%0d exp=0", pendCnt); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        wE = 1'b1; rW = 5'd2; busW = 32'h5; iE = 1'b1; rI = 5'd2;
        @(negedge clk);
        wE = 1'b0; iE = 1'b1; rI = 5'd6;
        @(negedge clk);
        idle_inputs(); rA = 5'd2; rB = 5'd6;
        #1;
        vectors++;
        if (busA !== 32'h5) begin miscompares++; $display("FAIL ar_pre_data busA=%h exp=%h", busA, 32'h5); end
        vectors++;
        if (pendCnt !== 6'd2) begin miscompares++; $display("FAIL ar_pre_pendcnt pendCnt=%0d exp=2", pendCnt); end
        vectors++;
        if ((pendA !== 1'b1) || (pendB !== 1'b1)) begin miscompares++; $display("FAIL ar_pre_pend pendA=%b pendB=%b exp=1 1", pendA, pendB); end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (pendCnt !== 6'd0) begin miscompares++; $display("FAIL ar_pendcnt pendCnt=%0d exp=0", pendCnt); end
        vectors++;
        if (busA !== 32'h0) begin miscompares++; $display("FAIL ar_busa busA=%h exp=%h", busA, 32'h0); end
        vectors++;
        if ((pendA !== 1'b0) || (pendB !== 1'b0)) begin miscompares++; $display("FAIL ar_pend pendA=%b pendB=%b exp=0 0", pendA, pendB); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ((busA !== 32'h0) || (pendCnt !== 6'd0)) begin miscompares++; $display("FAIL ar_after_release busA=%h pendCnt=%0d exp=0 0", busA, pendCnt); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rA = '0; rB = '0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_issue_write();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
